cosim_tohost_arbiter: RTL and testbench

//  Shares one Cosim_Endpoint_ToHost channel between NUM_CLIENTS valid/ready producers.

---
 rtl/cosim_tohost_arbiter.sv | 124 ++++++++++++
 tb/tb_cosim_tohost_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cosim_tohost_arbiter.sv
// Round-robin arbiter (optional burst lock) sharing one endpoint channel among NUM_CLIENTS producers.
// Latency 1 cycle; while the output register holds a message and OutReady is low, every InReady stays 0.
module cosim_tohost_arbiter #(
    parameter int NUM_CLIENTS = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int ID_WIDTH    = 2,
    parameter int MAX_BURST   = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_CLIENTS-1:0]            InValid,
    output logic [NUM_CLIENTS-1:0]            InReady,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] InData,
    output logic                              OutValid,
    input  logic                              OutReady,
    output logic [ID_WIDTH+DATA_WIDTH-1:0]    OutData,
    output logic [ID_WIDTH-1:0]               Owner
);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    generate
        if (ID_WIDTH != $clog2(NUM_CLIENTS)) begin : g_id_width_check
            $error("ID_WIDTH must equal $clog2(NUM_CLIENTS)");
        end
    endgenerate

    logic                           r_out_vld;
    logic [ID_WIDTH+DATA_WIDTH-1:0] r_out_dat;
    logic [ID_WIDTH-1:0]            r_owner;
    logic [ID_WIDTH-1:0]            r_ptr;
    logic [0:0]                     r_state;
    logic [CNT_W-1:0]               r_cnt;

    logic                w_load;
    logic                w_hold;
    logic                w_any;
    logic                w_xfer;
    logic [ID_WIDTH-1:0] w_start;
    logic [ID_WIDTH-1:0] w_winner;
    logic [ID_WIDTH-1:0] w_idx;

    function automatic logic [ID_WIDTH-1:0] f_next(input logic [ID_WIDTH-1:0] id);
        if (id == ID_WIDTH'(NUM_CLIENTS - 1)) return '0;
        return id + 1'b1;
    endfunction

    assign w_load = !r_out_vld || OutReady;
    assign w_hold = (r_state == S_BURST) && InValid[r_owner] && (r_cnt < CNT_W'(MAX_BURST));

    // A released burst searches from the slot after its owner in the same cycle.
    always_comb begin
        w_start = r_ptr;
        if (r_state == S_BURST && !w_hold) w_start = f_next(r_owner);
        w_winner = r_owner;
        w_any    = w_hold;
        w_idx    = w_start;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            if (!w_any && InValid[w_idx]) begin
                w_winner = w_idx;
                w_any    = 1'b1;
            end
            w_idx = f_next(w_idx);
        end
    end

    assign w_xfer   = w_load && w_any;
    assign InReady  = (rst && w_xfer) ? (NUM_CLIENTS'(1) << w_winner) : '0;
    assign OutValid = r_out_vld;
    assign OutData  = r_out_dat;
    assign Owner    = r_owner;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_vld <= 1'b0;
            r_out_dat <= '0;
            r_owner   <= '0;
            r_ptr     <= '0;
            r_state   <= S_IDLE;
            r_cnt     <= '0;
        end else if (w_load) begin
            if (w_xfer) begin
                r_out_vld <= 1'b1;
                r_out_dat <= {w_winner, InData[w_winner*DATA_WIDTH +: DATA_WIDTH]};
                r_owner   <= w_winner;
            end else begin
                r_out_vld <= 1'b0;
            end

            if (MAX_BURST == 1) begin
                if (w_xfer) r_ptr <= f_next(w_winner);
            end else if (r_state == S_IDLE) begin
                if (w_xfer) begin
                    r_state <= S_BURST;
                    r_cnt   <= CNT_W'(1);
                end
            end else if (w_hold) begin
                if (r_cnt == CNT_W'(MAX_BURST - 1)) begin
                    r_ptr   <= f_next(r_owner);
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                // Owner went quiet: hand the lock to whoever won the same-cycle search.
                r_ptr <= f_next(r_owner);
                if (w_xfer) begin
                    r_cnt <= CNT_W'(1);
                end else begin
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
            end
        end
    end

    a_inready_onehot0 : assert property (@(posedge clk) disable iff (!rst) $onehot0(InReady));
    a_out_stable      : assert property (@(posedge clk) disable iff (!rst)
                                         (OutValid && !OutReady) |=> $stable(OutData));
    a_no_xfer_stall   : assert property (@(posedge clk) disable iff (!rst)
                                         !w_load |-> ((InValid & InReady) == '0));
endmodule

// File: tb/tb_cosim_tohost_arbiter.sv
// Bench for cosim_tohost_arbiter: three instances (MAX_BURST 1, 3, 4) on shared inputs.
module tb_cosim_tohost_arbiter;
    localparam int N   = 4;
    localparam int W   = 32;
    localparam int IDW = 2;
    localparam int NG  = 3;

    logic             clk;
    logic             rst;
    logic [N-1:0]     in_vld;
    logic [N*W-1:0]   in_dat;
    logic             out_rdy;
    logic [N-1:0]     in_rdy  [NG];
    logic             out_vld [NG];
    logic [IDW+W-1:0] out_dat [NG];
    logic [IDW-1:0]   owner   [NG];

    int n_err = 0;
    int n_chk = 0;

    generate
        for (genvar g = 0; g < NG; g++) begin : g_dut
            localparam int MB = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
            cosim_tohost_arbiter #(
                .NUM_CLIENTS(N), .DATA_WIDTH(W), .ID_WIDTH(IDW), .MAX_BURST(MB)
            ) u_dut (
                .clk(clk), .rst(rst),
                .InValid(in_vld), .InReady(in_rdy[g]), .InData(in_dat),
                .OutValid(out_vld[g]), .OutReady(out_rdy), .OutData(out_dat[g]),
                .Owner(owner[g])
            );
        end
    endgenerate

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state (per instance)
    logic [IDW-1:0]   m_ptr  [NG];
    logic [IDW-1:0]   m_own  [NG];
    bit               m_live [NG];
    int               m_run  [NG];
    bit               m_vld  [NG];
    logic [IDW+W-1:0] m_dat  [NG];
    int               m_wait [NG][N];
    logic [IDW+W-1:0] sb_q   [NG][$];

    function automatic int mb_of(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    endfunction

    function automatic logic [W-1:0] pay(input int c, input int s);
        return 32'hD000_0000 + 32'(c * 65536 + s);
    endfunction

    task automatic set_data(input int s);
        for (int i = 0; i < N; i++) in_dat[i*W +: W] = pay(i, s);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        in_vld  = '0;
        out_rdy = 1'b1;
        #2 rst = 1'b1;
    endtask

    task automatic model_pick(input int g, output logic [IDW-1:0] w, output bit any);
        logic [IDW-1:0] idx;
        any = 1'b0;
        w   = '0;
        if (m_live[g] && in_vld[m_own[g]]) begin
            w   = m_own[g];
            any = 1'b1;
        end else begin
            idx = m_live[g] ? m_own[g] + 2'd1 : m_ptr[g];
            for (int k = 0; k < N; k++) begin
                if (!any && in_vld[idx]) begin
                    w   = idx;
                    any = 1'b1;
                end
                idx = idx + 2'd1;
            end
        end
    endtask

    task automatic model_commit(input int g, input logic [IDW-1:0] w, input bit any);
        int mb;
        mb = mb_of(g);
        if (m_live[g] && in_vld[m_own[g]]) begin
            m_run[g]++;
            if (m_run[g] == mb) begin
                m_live[g] = 1'b0;
                m_ptr[g]  = m_own[g] + 2'd1;
            end
        end else begin
            if (m_live[g]) begin
                m_live[g] = 1'b0;
                m_ptr[g]  = m_own[g] + 2'd1;
            end
            if (any) begin
                m_own[g] = w;
                m_run[g] = 1;
                if (mb > 1) m_live[g] = 1'b1;
                else        m_ptr[g]  = w + 2'd1;
            end
        end
        if (any) begin
            m_vld[g] = 1'b1;
            m_dat[g] = {w, in_dat[w*W +: W]};
            sb_q[g].push_back(m_dat[g]);
        end else begin
            m_vld[g] = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; out_rdy = 1'b1; in_vld = 4'b1111; set_data(0);
        #2;
        for (int g = 0; g < NG; g++) begin
            n_chk++; if (out_vld[g] !== 1'b0) begin n_err++; $display("FAIL reset_outvalid g=%0d got=%b want=0", g, out_vld[g]); end
            n_chk++; if (out_dat[g] !== '0) begin n_err++; $display("FAIL reset_outdata g=%0d got=%h want=0", g, out_dat[g]); end
            n_chk++; if (owner[g] !== 2'd0) begin n_err++; $display("FAIL reset_owner g=%0d got=%0d want=0", g, owner[g]); end
            n_chk++; if (in_rdy[g] !== 4'b0) begin n_err++; $display("FAIL reset_inready g=%0d got=%b want=0000", g, in_rdy[g]); end
        end
    endtask

    task automatic test_round_robin();
        int prev = 0;
        @(posedge clk);
        #1 rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_chk++;
            if (in_rdy[0] !== 4'(1 << (k % N))) begin
                n_err++; $display("FAIL rr_grant k=%0d got=%b want=%b", k, in_rdy[0], 4'(1 << (k % N)));
            end
            if (k > 0) begin
                n_chk++;
                if ({out_vld[0], out_dat[0]} !== {1'b1, IDW'(prev), pay(prev, 0)}) begin
                    n_err++; $display("FAIL rr_outdata k=%0d got=%b/%h want=1/%h", k, out_vld[0], out_dat[0], {IDW'(prev), pay(prev, 0)});
                end
            end
            prev = k % N;
        end
    endtask

    task automatic test_burst();
        int bs [9] = '{1, 1, 1, 2, 2, 2, 1, 1, 1};
        do_reset();
        in_vld = 4'b0110; out_rdy = 1'b1; set_data(0);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            n_chk++;
            if (in_rdy[1] !== 4'(1 << bs[k])) begin
                n_err++; $display("FAIL burst_grant k=%0d got=%b want=%b", k, in_rdy[1], 4'(1 << bs[k]));
            end
            if (k > 0) begin
                n_chk++;
                if (owner[1] !== IDW'(bs[k-1]) || out_dat[1][W +: IDW] !== IDW'(bs[k-1])) begin
                    n_err++; $display("FAIL burst_owner k=%0d got=%0d/%0d want=%0d", k, owner[1], out_dat[1][W +: IDW], bs[k-1]);
                end
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        in_vld = 4'b0001; out_rdy = 1'b1; set_data(0);
        @(negedge clk);
        for (int g = 0; g < NG; g++) begin
            n_chk++; if (in_rdy[g] !== 4'b0001) begin n_err++; $display("FAIL stall_first_grant g=%0d got=%b want=0001", g, in_rdy[g]); end
        end
        @(posedge clk);
        #1 out_rdy = 1'b0; set_data(1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            for (int g = 0; g < NG; g++) begin
                n_chk++;
                if (out_vld[g] !== 1'b1 || out_dat[g] !== {2'd0, pay(0, 0)} || in_rdy[g] !== 4'b0) begin
                    n_err++; $display("FAIL stall_hold c=%0d g=%0d got=%b/%h/%b want=1/%h/0000", c, g, out_vld[g], out_dat[g], in_rdy[g], {2'd0, pay(0, 0)});
                end
            end
            @(posedge clk);
            #1;
        end
        out_rdy = 1'b1;
        @(negedge clk);
        for (int g = 0; g < NG; g++) begin
            n_chk++;
            if (in_rdy[g] !== 4'b0001 || out_dat[g] !== {2'd0, pay(0, 0)}) begin
                n_err++; $display("FAIL stall_resume g=%0d got=%b/%h want=0001/%h", g, in_rdy[g], out_dat[g], {2'd0, pay(0, 0)});
            end
        end
        @(posedge clk);
        #1;
        for (int g = 0; g < NG; g++) begin
            n_chk++;
            if (out_vld[g] !== 1'b1 || out_dat[g] !== {2'd0, pay(0, 1)}) begin
                n_err++; $display("FAIL stall_next g=%0d got=%b/%h want=1/%h", g, out_vld[g], out_dat[g], {2'd0, pay(0, 1)});
            end
        end
        in_vld = '0;
    endtask

    task automatic test_release();
        do_reset();
        in_vld = 4'b1000; out_rdy = 1'b1; set_data(0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_chk++; if (in_rdy[2] !== 4'b1000) begin n_err++; $display("FAIL release_burst k=%0d got=%b want=1000", k, in_rdy[2]); end
            @(posedge clk);
        end
        #1 in_vld = 4'b0010;
        @(negedge clk);
        n_chk++;
        if (in_rdy[2] !== 4'b0010 || out_vld[2] !== 1'b1 || out_dat[2] !== {2'd3, pay(3, 0)}) begin
            n_err++; $display("FAIL release_same_cycle got=%b/%b/%h want=0010/1/%h", in_rdy[2], out_vld[2], out_dat[2], {2'd3, pay(3, 0)});
        end
        @(posedge clk);
        #1;
        n_chk++;
        if (out_vld[2] !== 1'b1 || out_dat[2] !== {2'd1, pay(1, 0)} || owner[2] !== 2'd1) begin
            n_err++; $display("FAIL release_newowner got=%b/%h/%0d want=1/%h/1", out_vld[2], out_dat[2], owner[2], {2'd1, pay(1, 0)});
        end
        in_vld = 4'b0011;
        @(negedge clk);
        n_chk++; if (in_rdy[2] !== 4'b0010) begin n_err++; $display("FAIL release_lock got=%b want=0010", in_rdy[2]); end
        @(posedge clk);
        #1 in_vld = '0;
    endtask

    task automatic test_async_reset();
        do_reset();
        in_vld = 4'b0100; out_rdy = 1'b1; set_data(0);
        @(posedge clk);
        #1;
        for (int g = 0; g < NG; g++) begin
            n_chk++; if (out_vld[g] !== 1'b1) begin n_err++; $display("FAIL areset_pre g=%0d got=%b want=1", g, out_vld[g]); end
        end
        out_rdy = 1'b0;
        #2 rst = 1'b0;
        #1;
        for (int g = 0; g < NG; g++) begin
            n_chk++;
            if (out_vld[g] !== 1'b0 || in_rdy[g] !== 4'b0 || out_dat[g] !== '0 || owner[g] !== 2'd0) begin
                n_err++; $display("FAIL areset_immediate g=%0d got=%b/%b/%h/%0d want=0/0000/0/0", g, out_vld[g], in_rdy[g], out_dat[g], owner[g]);
            end
        end
        in_vld = 4'b1111; out_rdy = 1'b1; rst = 1'b1;
        @(negedge clk);
        for (int g = 0; g < NG; g++) begin
            n_chk++; if (in_rdy[g] !== 4'b0001) begin n_err++; $display("FAIL areset_first_grant g=%0d got=%b want=0001", g, in_rdy[g]); end
        end
        @(posedge clk);
        #1 in_vld = '0;
    endtask

    task automatic test_random();
        logic [IDW-1:0]   w;
        bit               any;
        bit               load;
        logic [N-1:0]     exp_rdy;
        logic [IDW+W-1:0] exp_dat;
        do_reset();
        for (int g = 0; g < NG; g++) begin
            m_ptr[g] = '0; m_own[g] = '0; m_live[g] = 1'b0; m_run[g] = 0;
            m_vld[g] = 1'b0; m_dat[g] = '0; sb_q[g].delete();
            for (int i = 0; i < N; i++) m_wait[g][i] = 0;
        end
        for (int cyc = 0; cyc < 10006; cyc++) begin
            if (cyc < 10000) begin
                for (int i = 0; i < N; i++) begin
                    in_vld[i] = ($urandom_range(0, 3) != 0);
                    in_dat[i*W +: W] = $urandom;
                end
                out_rdy = ($urandom_range(0, 2) != 0);
            end else begin
                in_vld = '0; out_rdy = 1'b1;
            end
            @(negedge clk);
            for (int g = 0; g < NG; g++) begin
                n_chk++; if (out_vld[g] !== m_vld[g]) begin n_err++; $display("FAIL rnd_outvalid cyc=%0d g=%0d got=%b want=%b", cyc, g, out_vld[g], m_vld[g]); end
                if (m_vld[g]) begin
                    n_chk++; if (out_dat[g] !== m_dat[g]) begin n_err++; $display("FAIL rnd_outdata cyc=%0d g=%0d got=%h want=%h", cyc, g, out_dat[g], m_dat[g]); end
                end
                n_chk++; if (owner[g] !== m_own[g]) begin n_err++; $display("FAIL rnd_owner cyc=%0d g=%0d got=%0d want=%0d", cyc, g, owner[g], m_own[g]); end
                if (m_vld[g] && out_rdy) begin
                    n_chk++;
                    if (sb_q[g].size() == 0) begin
                        n_err++; $display("FAIL rnd_sb_empty cyc=%0d g=%0d got=%h want=none", cyc, g, out_dat[g]);
                    end else begin
                        exp_dat = sb_q[g].pop_front();
                        if (out_dat[g] !== exp_dat) begin n_err++; $display("FAIL rnd_sb_order cyc=%0d g=%0d got=%h want=%h", cyc, g, out_dat[g], exp_dat); end
                    end
                end
                load = !m_vld[g] || out_rdy;
                model_pick(g, w, any);
                exp_rdy = (load && any) ? (4'b0001 << w) : 4'b0;
                n_chk++; if (in_rdy[g] !== exp_rdy) begin n_err++; $display("FAIL rnd_inready cyc=%0d g=%0d got=%b want=%b", cyc, g, in_rdy[g], exp_rdy); end
                if (load) begin
                    for (int i = 0; i < N; i++) begin
                        if (in_vld[i] && !(any && w == IDW'(i))) begin
                            m_wait[g][i]++;
                            n_chk++;
                            if (m_wait[g][i] > (N - 1) * mb_of(g)) begin
                                n_err++; $display("FAIL rnd_starve cyc=%0d g=%0d client=%0d got=%0d want<=%0d", cyc, g, i, m_wait[g][i], (N - 1) * mb_of(g));
                            end
                        end else begin
                            m_wait[g][i] = 0;
                        end
                    end
                    model_commit(g, w, any);
                end
            end
            @(posedge clk);
            #1;
        end
        for (int g = 0; g < NG; g++) begin
            n_chk++; if (sb_q[g].size() != 0 || out_vld[g] !== 1'b0) begin n_err++; $display("FAIL rnd_drain g=%0d got=%0d/%b want=0/0", g, sb_q[g].size(), out_vld[g]); end
        end
    endtask

    initial begin
        in_vld = '0; in_dat = '0; out_rdy = 1'b1;
        test_reset();
        test_round_robin();
        test_burst();
        test_stall();
        test_release();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
